alu_share_ctrl: RTL and testbench

Sequencing and arbitration controller that shares the single combinational 32-bit ALU between two requesters (e.g. the execute stage and a multi-cycle helper unit). It accepts operations over valid/ready handshakes, grants the ALU round-robin, drives the ALU operand and select inputs for one execute cycle, and registers the result. It returns each result on a per-requester response channel and holds it until that requester accepts it. Illegal operations are screened before the ALU sees them.

---
 rtl/alu_share_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one external combinational ALU between two requesters. Operations
// are accepted over valid/ready handshakes, granted round-robin, executed for
// exactly one cycle on the ALU pins, and the registered result is returned on
// the winning requester's response channel until that requester accepts it.
// Illegal select codes and divide-by-zero are screened: the ALU stays idle
// (alu_sel = 0) and the response carries err = 1, res = 0.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid/ready           operation handshake for requester N
//   reqN_op1/op2/sel           operation payload for requester N
//   rspN_valid/ready           result handshake for requester N
//   rspN_res/err               result and reject flag (0 when rspN_valid = 0)
//   alu_op1/op2/sel            drive to the shared ALU (0 outside EXEC)
//   alu_res                    result from the shared ALU
// ---------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int SELW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [SELW-1:0]  req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [SELW-1:0]  req1_sel,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_res,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_res,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [SELW-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_res
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic             gnt_id_q, gnt_id_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;

    logic             grant0_s;
    logic             grant1_s;
    logic             legal_s;
    logic             rsp_take_s;

    // Legal ops are select codes 1..8, excluding divide with a zero divisor.
    function automatic logic op_legal(input logic [SELW-1:0]  sel,
                                      input logic [WIDTH-1:0] divisor);
        logic in_range;
        logic div_zero;
        in_range = (sel >= SELW'(4'd1)) && (sel <= SELW'(4'd8));
        div_zero = (sel == SELW'(4'd4)) && (divisor == {WIDTH{1'b0}});
        return in_range && !div_zero;
    endfunction

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op1_q    <= {WIDTH{1'b0}};
            op2_q    <= {WIDTH{1'b0}};
            sel_q    <= {SELW{1'b0}};
            gnt_id_q <= 1'b0;
            prio_q   <= 1'b0;
            res_q    <= {WIDTH{1'b0}};
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            sel_q    <= sel_d;
            gnt_id_q <= gnt_id_d;
            prio_q   <= prio_d;
            res_q    <= res_d;
            err_q    <= err_d;
        end
    end

    // Next-state, arbitration and ALU drive.
    always_comb begin
        state_d    = state_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        sel_d      = sel_q;
        gnt_id_d   = gnt_id_q;
        prio_d     = prio_q;
        res_d      = res_q;
        err_d      = err_q;
        grant0_s   = 1'b0;
        grant1_s   = 1'b0;
        alu_op1    = {WIDTH{1'b0}};
        alu_op2    = {WIDTH{1'b0}};
        alu_sel    = {SELW{1'b0}};
        legal_s    = op_legal(sel_q, op2_q);
        // Only the owner of the pending response can complete it.
        rsp_take_s = gnt_id_q ? rsp1_ready : rsp0_ready;

        case (state_q)
            ST_IDLE: begin
                // req0 wins when alone or when it holds priority on a tie.
                if (req0_valid && (!req1_valid || (prio_q == 1'b0))) begin
                    grant0_s = 1'b1;
                end else if (req1_valid) begin
                    grant1_s = 1'b1;
                end else begin
                    grant0_s = 1'b0;
                end

                if (grant0_s) begin
                    op1_d    = req0_op1;
                    op2_d    = req0_op2;
                    sel_d    = req0_sel;
                    gnt_id_d = 1'b0;
                    prio_d   = 1'b1;
                    state_d  = ST_EXEC;
                end else if (grant1_s) begin
                    op1_d    = req1_op1;
                    op2_d    = req1_op2;
                    sel_d    = req1_sel;
                    gnt_id_d = 1'b1;
                    prio_d   = 1'b0;
                    state_d  = ST_EXEC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_EXEC: begin
                if (legal_s) begin
                    alu_op1 = op1_q;
                    alu_op2 = op2_q;
                    alu_sel = sel_q;
                    res_d   = alu_res;
                    err_d   = 1'b0;
                end else begin
                    // The ALU never sees a rejected op.
                    res_d   = {WIDTH{1'b0}};
                    err_d   = 1'b1;
                end
                state_d = ST_RESP;
            end

            ST_RESP: begin
                if (rsp_take_s) begin
                    res_d   = {WIDTH{1'b0}};
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    assign rsp0_valid = (state_q == ST_RESP) && (gnt_id_q == 1'b0);
    assign rsp1_valid = (state_q == ST_RESP) && (gnt_id_q == 1'b1);
    assign rsp0_res   = rsp0_valid ? res_q : {WIDTH{1'b0}};
    assign rsp1_res   = rsp1_valid ? res_q : {WIDTH{1'b0}};
    assign rsp0_err   = rsp0_valid & err_q;
    assign rsp1_err   = rsp1_valid & err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_share_ctrl
//
// Self-checking bench: a behavioural ALU sits on the alu_* pins, and a
// pending-operation model (per-requester slot plus a "favoured requester"
// variable) predicts grants, the ALU drive during execute, and each response.
// ---------------------------------------------------------------------------
module tb_alu_share_ctrl;

    localparam int WIDTH = 32;
    localparam int SELW  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [SELW-1:0]  req0_sel, req1_sel;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp0_res, rsp1_res;
    logic             rsp0_err, rsp1_err;
    logic [WIDTH-1:0] alu_op1, alu_op2, alu_res;
    logic [SELW-1:0]  alu_sel;

    int n_vec = 0;
    int n_err = 0;

    // Pending operation per requester, and who wins the next tie.
    logic             p_v [2];
    logic [WIDTH-1:0] p_a [2];
    logic [WIDTH-1:0] p_b [2];
    logic [SELW-1:0]  p_s [2];
    int               prio_m;

    alu_share_ctrl #(.WIDTH(WIDTH), .SELW(SELW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sel(req1_sel),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_res(rsp0_res), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_res(rsp1_res), .rsp1_err(rsp1_err),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
        .alu_res(alu_res)
    );

    always #5 clk = ~clk;

    // Behavioural shared ALU; idle/unknown selects return a marker value.
    always_comb begin
        case (alu_sel)
            4'd1: alu_res = alu_op1 + alu_op2;
            4'd2: alu_res = alu_op1 - alu_op2;
            4'd3: alu_res = alu_op1 * alu_op2;
            4'd4: alu_res = (alu_op2 == 32'd0) ? 32'hDEAD_BEEF : alu_op1 / alu_op2;
            4'd5: alu_res = alu_op1 | alu_op2;
            4'd6: alu_res = alu_op1 ^ alu_op2;
            4'd7: alu_res = alu_op1;
            4'd8: alu_res = (alu_op1 < alu_op2) ? 32'd1 : 32'd0;
            default: alu_res = 32'hA5A5_A5A5;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected response from the operation rules.
    function automatic void ref_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
        longint unsigned prod;
        e = 1'b0;
        r = 32'd0;
        case (s)
            4'd1: r = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'd2: r = 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
            4'd3: begin prod = 64'(a) * 64'(b); r = prod[31:0]; end
            4'd4: if (b == 32'd0) e = 1'b1; else r = a / b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = a;
            4'd8: r = (a < b) ? 32'd1 : 32'd0;
            default: e = 1'b1;
        endcase
    endfunction

    task automatic drive_reqs();
        req0_valid = p_v[0]; req0_op1 = p_a[0]; req0_op2 = p_b[0]; req0_sel = p_s[0];
        req1_valid = p_v[1]; req1_op1 = p_a[1]; req1_op2 = p_b[1]; req1_sel = p_s[1];
    endtask

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        p_v[id] = 1'b1; p_a[id] = a; p_b[id] = b; p_s[id] = s;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
        check_val({tag, "_rsp_valid"}, 32'({rsp0_valid, rsp1_valid}), 32'd0);
        check_val({tag, "_rsp_err"}, 32'({rsp0_err, rsp1_err}), 32'd0);
        check_val({tag, "_rsp0_res"}, rsp0_res, 32'd0);
        check_val({tag, "_rsp1_res"}, rsp1_res, 32'd0);
        check_val({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
        check_val({tag, "_alu_ops"}, alu_op1 | alu_op2, 32'd0);
    endtask

    task automatic check_rsp(input int win, input logic [31:0] er, input logic ee);
        check_val("rsp0_valid", 32'(rsp0_valid), 32'(win == 0));
        check_val("rsp1_valid", 32'(rsp1_valid), 32'(win == 1));
        check_val("rsp0_res", rsp0_res, (win == 0) ? er : 32'd0);
        check_val("rsp1_res", rsp1_res, (win == 1) ? er : 32'd0);
        check_val("rsp0_err", 32'(rsp0_err), 32'((win == 0) && ee));
        check_val("rsp1_err", 32'(rsp1_err), 32'((win == 1) && ee));
        check_val("resp_req_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check_val("resp_alu_sel", 32'(alu_sel), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        drive_reqs();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        prio_m = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One full operation: arbitration, execute, response (held 'hold' cycles).
    // Entered and left 1 time unit after a rising edge with the DUT idle.
    task automatic cycle_op(input int hold, input bit rand_other);
        int          win;
        int          oth;
        logic [31:0] er;
        logic        ee;
        drive_reqs();
        if (p_v[0] && p_v[1]) win = prio_m;
        else if (p_v[0])      win = 0;
        else                  win = 1;
        oth = 1 - win;
        @(negedge clk);
        check_val("req0_ready", 32'(req0_ready), 32'(win == 0));
        check_val("req1_ready", 32'(req1_ready), 32'(win == 1));
        check_val("idle_alu_sel", 32'(alu_sel), 32'd0);
        check_val("idle_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        @(posedge clk); #1;
        ref_op(p_s[win], p_a[win], p_b[win], er, ee);
        p_v[win] = 1'b0;
        prio_m = oth;
        drive_reqs();
        @(negedge clk);
        check_val("exec_alu_sel", 32'(alu_sel), ee ? 32'd0 : 32'(p_s[win]));
        check_val("exec_alu_op1", alu_op1, ee ? 32'd0 : p_a[win]);
        check_val("exec_alu_op2", alu_op2, ee ? 32'd0 : p_b[win]);
        check_val("exec_req_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check_val("exec_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < hold; i++) begin
            if (rand_other) begin
                if (oth == 0) rsp0_ready = 1'($urandom_range(0, 1));
                else          rsp1_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check_rsp(win, er, ee);
            @(posedge clk); #1;
        end
        rsp0_ready = (win == 0);
        rsp1_ready = (win == 1);
        @(negedge clk);
        check_rsp(win, er, ee);
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] s;
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        p_a[0] = 32'd0; p_a[1] = 32'd0; p_b[0] = 32'd0; p_b[1] = 32'd0;
        p_s[0] = 4'd0; p_s[1] = 4'd0;
        rst_n = 1'b0;
        drive_reqs();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Basic add on requester 0.
        set_op(0, 32'd7, 32'd5, 4'd1);
        cycle_op(0, 1'b0);

        // Simultaneous requests after reset: req0 first, then req1.
        do_reset();
        set_op(0, 32'd3, 32'd5, 4'd2);
        set_op(1, 32'h0000_00F0, 32'h0000_000F, 4'd6);
        cycle_op(0, 1'b0);
        cycle_op(0, 1'b0);
        set_op(0, 32'd100, 32'd1, 4'd7);
        set_op(1, 32'd9, 32'd4, 4'd5);
        cycle_op(0, 1'b0);
        cycle_op(0, 1'b0);

        // Divide by zero rejected, then a legal divide.
        set_op(1, 32'd10, 32'd0, 4'd4);
        cycle_op(0, 1'b0);
        set_op(1, 32'd10, 32'd3, 4'd4);
        cycle_op(0, 1'b0);

        // Illegal selects and unsigned set-less-than.
        set_op(0, 32'd1, 32'd2, 4'd0);
        cycle_op(0, 1'b0);
        set_op(0, 32'd1, 32'd2, 4'd9);
        cycle_op(1, 1'b0);
        set_op(0, 32'd2, 32'hFFFF_FFFF, 4'd8);
        cycle_op(0, 1'b0);
        set_op(0, 32'd5, 32'd5, 4'd8);
        cycle_op(0, 1'b0);

        // Held response with a waiting competitor.
        set_op(1, 32'd1, 32'd1, 4'd1);
        cycle_op(0, 1'b0);
        set_op(0, 32'h1234_5678, 32'h0000_FFFF, 4'd3);
        set_op(1, 32'd50, 32'd8, 4'd2);
        cycle_op(4, 1'b0);
        cycle_op(0, 1'b0);

        // Reset during execute aborts the op; priority returns to req0.
        set_op(0, 32'd11, 32'd22, 4'd1);
        drive_reqs();
        @(negedge clk);
        check_val("abort_accept", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        p_v[0] = 1'b0;
        drive_reqs();
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        prio_m = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("abort_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
            @(posedge clk); #1;
        end
        set_op(0, 32'h0001_0000, 32'h0001_0000, 4'd3);
        set_op(1, 32'd6, 32'd7, 4'd1);
        cycle_op(0, 1'b0);
        cycle_op(0, 1'b0);

        // Randomised traffic.
        for (int it = 0; it < 80; it++) begin
            for (int id = 0; id < 2; id++) begin
                if (!p_v[id] && ($urandom_range(0, 2) != 0)) begin
                    s = 4'($urandom_range(0, 10));
                    set_op(id, $urandom, ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom, s);
                end
            end
            if (!p_v[0] && !p_v[1]) set_op(0, $urandom, $urandom, 4'($urandom_range(1, 8)));
            cycle_op($urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
